sseg_scan: RTL and testbench
============================

# sseg_scan

Four-digit multiplexed display scanner sitting directly upstream of the seven-segment decoder. It holds a 16-bit hex value, updates it tear-free at frame boundaries, time-multiplexes one nibble at a time onto `digit_o` for the decoder, and drives active-low anode and decimal-point lines. Per-slot guard time suppresses ghosting. Optional leading-zero blanking is supported.

## Interface
Parameters:
- `DIV`, 50000: clock cycles per digit slot; legal range is `DIV >= GUARD+2`.
- `GUARD`, 16: cycles at the start of each slot with all anodes off; legal range is `GUARD >= 1`.

Ports:
- `clk_i`  in  1  system clock; the single clock domain.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `value_i`  in  16  hex value; nibble k goes to digit k (digit 0 = `value_i[3:0]`, rightmost).
- `dp_i`  in  4  decimal point per digit, active-high, sampled with `value_i`.
- `load_i`  in  1  one-cycle strobe that captures `value_i` and `dp_i` into staging.
- `lzb_en_i`  in  1  leading-zero blanking enable (level).
- `enable_i`  in  1  display enable (level); when 0, all anodes are off.
- `digit_o`  out  4  nibble of the current slot; connects to the decoder's `data_i`.
- `an_o`  out  4  anode enables, active-low, one-hot-low or all-high.
- `dp_o`  out  1  decimal point, active-low.
- `upd_o`  out  1  one-cycle pulse when staging is transferred to the display register.

## Operation
- Registers:
  - prescaler `cnt` counts 0..DIV-1;
  - slot index `s` counts 0..3;
  - staging register `stg` holds 16 bits plus 4 dp bits;
  - `pend` flag;
  - display register `disp` holds 16 bits plus 4 dp bits.
- Load: `load_i`=1 writes `stg` from `value_i`/`dp_i` and sets `pend`. Back-to-back loads: the last one wins.
- Frame boundary is `cnt==DIV-1 && s==3`. At the boundary, if `pend` is set:
  - `disp` <= `stg` (contents before this cycle's write);
  - `pend` is cleared;
  - `upd_o` pulses in the next cycle.
- Simultaneous `load_i` and boundary: the transfer uses the old `stg`. The new load lands in `stg` and `pend` stays set, so it transfers at the next boundary.
- Slot sequencing:
  - `cnt` wraps at DIV-1 and increments `s`;
  - `s` wraps 3→0;
  - counters run regardless of `enable_i`.
- Within each slot:
  - the first GUARD cycles have `an_o`=4'hF and `dp_o`=1;
  - the remaining DIV-GUARD cycles drive `an_o[s]`=0 (others 1) and `dp_o`=~`disp.dp[s]`, unless the digit is suppressed.
- `digit_o` = `disp` nibble s. It changes on the first cycle of the slot, i.e. inside the guard window, never while an anode is active.
- Digit k (k≥1) is suppressed when `lzb_en_i`=1 and nibbles k..3 of `disp` are all zero. Digit 0 is never suppressed.
- A suppressed digit, or `enable_i`=0, gives `an_o`=4'hF and `dp_o`=1 for that slot's whole duration.
- Changes to `enable_i` or `lzb_en_i` take effect at the cycle boundary after sampling. No cycle may have two anodes active.

## Timing
- All outputs are registered.
- Reset values: `an_o`=4'hF, `dp_o`=1, `digit_o`=0, `upd_o`=0, `cnt`=0, `s`=0, `disp`=0, `stg`=0, `pend`=0.
- First slot (s=0) starts on the first clock edge after `rst_n_i` deasserts. Its guard occupies that edge through GUARD cycles. `an_o[0]` goes low on cycle GUARD (0-based count from release).
- Slot period is DIV cycles; frame period is 4·DIV cycles.
- Load-to-display latency:
  - minimum 1 cycle (load one cycle before a boundary);
  - maximum 4·DIV cycles;
  - `upd_o` and the new `digit_o` of slot 0 appear on the same cycle.
- Reset mid-frame returns all outputs to reset values immediately (asynchronous) and discards pending data.

## Test plan
Simulate with DIV=8, GUARD=2.
- After reset, with `enable_i`=1 and no load: `an_o` sequence per 8 cycles is F,F,E×6, then F,F,D×6, F,F,B×6, F,F,7×6; `digit_o`=0 throughout; `dp_o`=1.
- Load `value_i`=16'h12A5, `dp_i`=4'b0100 mid-frame: `upd_o` pulses exactly at the next frame start. `digit_o` then reads 5,A,2,1 in slots 0..3. `dp_o`=0 only during the active window of slot 2.
- Load 16'h0007 with `lzb_en_i`=1: only slot 0 is active (`an_o`=E, `digit_o`=7). Slots 1–3 hold `an_o`=F. With `lzb_en_i`=0, all four slots are active.
- Load 16'h1111 at the cycle `cnt`=7, `s`=3, then 16'h2222 exactly at the next boundary: the first `upd_o` shows 1111, the second `upd_o` one frame later shows 2222.
- `enable_i`=0 for one full frame: `an_o`=F and `dp_o`=1 throughout; `cnt`/`s` keep advancing, so the frame phase is unchanged upon re-enable.
- Assert `rst_n_i`=0 mid-slot 2 with a pending load: `an_o`=F immediately. After release, `disp`=0 and no `upd_o` occurs.

Source files
------------

// File: rtl/sseg_scan.sv
// Four-digit multiplexed seven-segment scanner with tear-free frame updates,
// per-slot anode guard time and optional leading-zero blanking.
module sseg_scan #(
    parameter int DIV   = 50000,
    parameter int GUARD = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] value_i,
    input  logic [3:0]  dp_i,
    input  logic        load_i,
    input  logic        lzb_en_i,
    input  logic        enable_i,
    output logic [3:0]  digit_o,
    output logic [3:0]  an_o,
    output logic        dp_o,
    output logic        upd_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    s, s_n;
    logic [15:0]   stg_v, disp_v, disp_vn;
    logic [3:0]    stg_dp, disp_dp, disp_dpn;
    logic          pend, pend_n;
    logic          wrap, xfer;
    logic          guard, blank, on;
    logic [3:0]    nz;
    logic [3:0]    an_n, digit_n;
    logic          dp_n;

    assign wrap = (cnt == CW'(DIV - 1));
    assign xfer = wrap && (s == 2'd3) && pend;

    always_comb begin
        cnt_n    = wrap ? '0 : cnt + 1'b1;
        s_n      = wrap ? s + 2'd1 : s;
        disp_vn  = xfer ? stg_v : disp_v;
        disp_dpn = xfer ? stg_dp : disp_dp;
        pend_n   = load_i ? 1'b1 : (xfer ? 1'b0 : pend);
    end

    // Outputs are registered from next-state values so they line up with cnt/s.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            nz[k] = (disp_vn[4*k +: 4] == 4'h0);
        end
        blank = 1'b0;
        case (s_n)
            2'd1:    blank = lzb_en_i & nz[1] & nz[2] & nz[3];
            2'd2:    blank = lzb_en_i & nz[2] & nz[3];
            2'd3:    blank = lzb_en_i & nz[3];
            default: blank = 1'b0;
        endcase
        guard   = (cnt_n < CW'(GUARD));
        on      = enable_i & ~guard & ~blank;
        an_n    = on ? ~(4'b0001 << s_n) : 4'hF;
        dp_n    = on ? ~disp_dpn[s_n] : 1'b1;
        digit_n = disp_vn[{s_n, 2'b00} +: 4];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt     <= '0;
            s       <= '0;
            stg_v   <= '0;
            stg_dp  <= '0;
            pend    <= 1'b0;
            disp_v  <= '0;
            disp_dp <= '0;
            an_o    <= 4'hF;
            dp_o    <= 1'b1;
            digit_o <= 4'h0;
            upd_o   <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            s       <= s_n;
            pend    <= pend_n;
            disp_v  <= disp_vn;
            disp_dp <= disp_dpn;
            if (load_i) begin
                stg_v  <= value_i;
                stg_dp <= dp_i;
            end
            an_o    <= an_n;
            dp_o    <= dp_n;
            digit_o <= digit_n;
            upd_o   <= xfer;
        end
    end

endmodule

// File: tb/tb_sseg_scan.sv
// Scoreboard bench for sseg_scan: a frame-time reference model queues the
// expected outputs per cycle, a negedge monitor pops and compares them.
module tb_sseg_scan;

    localparam int DIV   = 8;
    localparam int GUARD = 2;
    localparam int FRAME = 4 * DIV;

    typedef struct {
        logic [3:0] an;
        logic       dp;
        logic [3:0] digit;
        logic       upd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] val = '0;
    logic [3:0]  dpi = '0;
    logic        load = 1'b0;
    logic        lzb = 1'b0;
    logic        en = 1'b1;
    logic [3:0]  digit, an;
    logic        dp, upd;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // reference model state
    int unsigned m_t = 0;
    logic [15:0] m_disp = '0, m_stg = '0;
    logic [3:0]  m_ddp = '0, m_sdp = '0;
    bit          m_pend = 0, m_en = 0, m_lzb = 0;

    sseg_scan #(.DIV(DIV), .GUARD(GUARD)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .value_i(val), .dp_i(dpi),
        .load_i(load), .lzb_en_i(lzb), .enable_i(en),
        .digit_o(digit), .an_o(an), .dp_o(dp), .upd_o(upd)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_out(bit u);
        exp_t e;
        int p, slot, c;
        bit blank, on;
        p     = int'(m_t % FRAME);
        slot  = p / DIV;
        c     = p % DIV;
        blank = m_lzb && slot > 0 && ((m_disp >> (4 * slot)) == 16'h0);
        on    = m_en && c >= GUARD && !blank;
        e.an    = on ? (4'hF ^ (4'b0001 << slot)) : 4'hF;
        e.dp    = on ? !m_ddp[slot] : 1'b1;
        e.digit = 4'((m_disp >> (4 * slot)) & 16'hF);
        e.upd   = u;
        return e;
    endfunction

    // One clock edge: advance the model with the inputs sampled at that edge.
    task automatic step();
        bit u;
        @(posedge clk);
        #1;
        u = 0;
        if ((m_t % FRAME) == FRAME - 1 && m_pend) begin
            m_disp = m_stg;
            m_ddp  = m_sdp;
            m_pend = 0;
            u      = 1;
        end
        if (load) begin
            m_stg  = val;
            m_sdp  = dpi;
            m_pend = 1;
        end
        m_en  = en;
        m_lzb = lzb;
        m_t++;
        q.push_back(model_out(u));
    endtask

    task automatic drive(bit l, logic [15:0] v, logic [3:0] d);
        load = l;
        val  = v;
        dpi  = d;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            drive(0, val, dpi);
            step();
        end
    endtask

    task automatic align_to(int phase);
        drive(0, val, dpi);
        while ((m_t % FRAME) != phase) step();
    endtask

    task automatic do_reset(int n);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        load  = 1'b0;
        m_t = 0; m_disp = '0; m_stg = '0; m_ddp = '0; m_sdp = '0;
        m_pend = 0;
        q.push_back(model_out(0));
        for (int i = 1; i < n; i++) begin
            @(posedge clk);
            #1;
            q.push_back(model_out(0));
        end
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks += 4;
            if (an !== e.an) begin
                errors++;
                $display("FAIL an t=%0d got %h want %h", m_t, an, e.an);
            end
            if (dp !== e.dp) begin
                errors++;
                $display("FAIL dp t=%0d got %b want %b", m_t, dp, e.dp);
            end
            if (digit !== e.digit) begin
                errors++;
                $display("FAIL digit t=%0d got %h want %h", m_t, digit, e.digit);
            end
            if (upd !== e.upd) begin
                errors++;
                $display("FAIL upd t=%0d got %b want %b", m_t, upd, e.upd);
            end
        end
    end

    initial begin
        do_reset(3);
        idle(FRAME + 4);

        // mid-frame load with decimal point on digit 2
        drive(1, 16'h12A5, 4'b0100);
        step();
        idle(2 * FRAME);

        // leading-zero blanking on and off
        lzb = 1'b1;
        drive(1, 16'h0007, 4'b0000);
        step();
        idle(2 * FRAME);
        lzb = 1'b0;
        idle(FRAME);

        // load exactly at a boundary, then again at the next one
        align_to(FRAME - 1);
        drive(1, 16'h1111, 4'b0001);
        step();
        align_to(FRAME - 1);
        drive(1, 16'h2222, 4'b0010);
        step();
        idle(2 * FRAME + 2);

        // load one cycle before a boundary
        align_to(FRAME - 2);
        drive(1, 16'h0BEE, 4'b1000);
        step();
        idle(4);

        // display disabled for one frame
        align_to(FRAME - 1);
        en = 1'b0;
        idle(FRAME);
        en = 1'b1;
        idle(FRAME);

        // reset mid slot 2 with a pending load
        drive(1, 16'hFACE, 4'b1111);
        step();
        align_to(2 * DIV + 3);
        do_reset(3);
        idle(2 * FRAME);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [15:0] v;
            v = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
            if ($urandom_range(0, 49) == 0) lzb = ~lzb;
            if ($urandom_range(0, 59) == 0) en = ~en;
            drive($urandom_range(0, 9) == 0, v, 4'($urandom));
            step();
        end
        idle(FRAME);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
